// File: rtl/nn_layer_sequencer_if.sv
// nn_layer_sequencer_if: byte-wide activation, weight and result handshakes of the layer sequencer
interface nn_layer_sequencer_if;
  logic       start;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [7:0] w;
  logic       w_valid;
  logic       w_ready;
  logic [7:0] out;
  logic [3:0] out_idx;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  modport master (
    output start, din, din_valid, w, w_valid, out_ready,
    input  din_ready, w_ready, out, out_idx, out_valid, busy, done
  );
  modport slave (
    input  start, din, din_valid, w, w_valid, out_ready,
    output din_ready, w_ready, out, out_idx, out_valid, busy, done
  );
endinterface

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: one FC layer on a shared 8x8 MAC with ReLU/saturation; define NN_BIAS_EN for a leading bias beat per neuron
module nn_layer_sequencer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2,
  parameter int ACC_W = 20,
  parameter int SHIFT = 0
) (
  input logic clk,
  input logic rst,
  nn_layer_sequencer_if.slave bus
);
  localparam int IW = $clog2(N_IN);
  typedef enum logic [2:0] {IDLE, LOAD_X, MAC, EMIT, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] i_q, i_d, k_q, k_d;
  logic [3:0] j_q, j_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, acc_sh;
  logic signed [7:0] x_q [N_IN];
  logic signed [7:0] x_d [N_IN];
  logic [7:0] out_q, out_d, act;
  logic signed [15:0] prod;
`ifdef NN_BIAS_EN
  logic bias_q, bias_d;
`endif
  assign prod    = x_q[k_q] * $signed(bus.w);
  assign acc_sum = acc_q + {{(ACC_W-16){prod[15]}}, prod};
  assign acc_sh  = acc_sum >>> SHIFT;
  assign act     = acc_sh[ACC_W-1] ? 8'd0 : (|acc_sh[ACC_W-2:7] ? 8'd127 : acc_sh[7:0]);
  assign bus.din_ready = state_q == LOAD_X;
  assign bus.w_ready   = state_q == MAC;
  assign bus.out_valid = state_q == EMIT;
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = state_q == DONE;
  assign bus.out       = out_q;
  assign bus.out_idx   = j_q;
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    k_d = k_q;
    j_d = j_q;
    acc_d = acc_q;
    out_d = out_q;
    x_d = x_q;
`ifdef NN_BIAS_EN
    bias_d = bias_q;
`endif
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD_X;
        i_d = '0;
      end
      LOAD_X: if (bus.din_valid) begin
        x_d[i_q] = $signed(bus.din);
        i_d = i_q + 1'b1;
        if (i_q == IW'(N_IN-1)) begin
          state_d = MAC;
          j_d = '0;
          k_d = '0;
          acc_d = '0;
`ifdef NN_BIAS_EN
          bias_d = 1'b1;
`endif
        end
      end
      MAC: if (bus.w_valid) begin
`ifdef NN_BIAS_EN
        if (bias_q) begin
          acc_d = {{(ACC_W-8){bus.w[7]}}, bus.w} <<< SHIFT;
          bias_d = 1'b0;
        end else begin
`else
        begin
`endif
          acc_d = acc_sum;
          k_d = k_q + 1'b1;
          if (k_q == IW'(N_IN-1)) begin
            state_d = EMIT;
            out_d = act;
          end
        end
      end
      EMIT: if (bus.out_ready) begin
        if (j_q == 4'(N_OUT-1)) state_d = DONE;
        else begin
          state_d = MAC;
          j_d = j_q + 1'b1;
          k_d = '0;
          acc_d = '0;
`ifdef NN_BIAS_EN
          bias_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      i_q <= '0;
      k_q <= '0;
      j_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      x_q <= '{default: '0};
`ifdef NN_BIAS_EN
      bias_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      k_q <= k_d;
      j_q <= j_d;
      acc_q <= acc_d;
      out_q <= out_d;
      x_q <= x_d;
`ifdef NN_BIAS_EN
      bias_q <= bias_d;
`endif
    end
endmodule

// File: tb/tb_nn_layer_sequencer.sv
// tb_nn_layer_sequencer: randomized scoreboard bench for nn_layer_sequencer against an arithmetic layer model
module tb_nn_layer_sequencer;
  localparam int N_IN = 4, N_OUT = 2, ACC_W = 20, SHIFT = 2;
`ifdef NN_BIAS_EN
  localparam bit HAS_BIAS = 1'b1;
`else
  localparam bit HAS_BIAS = 1'b0;
`endif
  typedef struct {int out; int idx;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, bp_mode = 0;
  int xv[N_IN];
  int wv[N_OUT][N_IN];
  int bv[N_OUT];
  nn_layer_sequencer_if bus();
  nn_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // Layer result from plain arithmetic: dot product plus scaled bias, divide, clamp to 0..127.
  function automatic int model(int j);
    int acc = HAS_BIAS ? bv[j] * (1 << SHIFT) : 0;
    int v;
    for (int i = 0; i < N_IN; i++) acc += xv[i] * wv[j][i];
    v = acc / (1 << SHIFT);
    return v < 0 ? 0 : (v > 127 ? 127 : v);
  endfunction
  function automatic int outs_word();
    return int'({bus.out, bus.out_idx, bus.out_valid, bus.din_ready, bus.w_ready, bus.busy, bus.done});
  endfunction
  task automatic send_din(int v);
    int n = 0;
    bus.din = 8'(v);
    bus.din_valid = 1'b1;
    while (!bus.din_ready && n < 50) begin tick(); n++; end
    chk("din_ready_wait", int'(bus.din_ready), 1);
    tick();
    bus.din_valid = 1'b0;
  endtask
  task automatic send_w(int v, bit start_too);
    int n = 0;
    bus.w = 8'(v);
    bus.w_valid = 1'b1;
    while (!bus.w_ready && n < 50) begin tick(); n++; end
    chk("w_ready_wait", int'(bus.w_ready), 1);
    bus.start = start_too;
    tick();
    bus.w_valid = 1'b0;
    bus.start = 1'b0;
  endtask
  task automatic run_pass(bit din_stall, bit mac_start, bit done_start, int abort_at);
    int n = 0, cnt = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("busy_after_start", int'(bus.busy), 1);
    for (int i = 0; i < N_IN; i++) begin
      if (din_stall || (bp_mode == 2 && $urandom_range(0, 2) == 0)) tick();
      send_din(xv[i]);
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (HAS_BIAS) send_w(bv[j], 1'b0);
      for (int i = 0; i < N_IN; i++) begin
        if (cnt == abort_at) begin
          rst = 1'b1;
          tick();
          chk("reset_outputs", outs_word(), 0);
          rst = 1'b0;
          sb.delete();
          return;
        end
        if (bp_mode == 2 && $urandom_range(0, 3) == 0) tick();
        send_w(wv[j][i], mac_start && j == 0 && i == 1);
        cnt++;
      end
      sb.push_back('{out: model(j), idx: j});
      chk("latency_valid", int'(bus.out_valid), 1);
      chk("latency_idx", int'(bus.out_idx), j);
    end
    while (!bus.done && n < 200) begin tick(); n++; end
    chk("done_seen", int'(bus.done), 1);
    chk("sb_drained", sb.size(), 0);
    bus.start = done_start;
    tick();
    bus.start = 1'b0;
    chk("busy_after_done", int'(bus.busy), 0);
    chk("done_pulse_len", int'(bus.done), 0);
  endtask
  task automatic set_basic();
    xv = '{1, 2, 3, 4};
    wv = '{'{1, 1, 1, 1}, '{-1, -1, -1, -1}};
    bv = '{-5, -5};
  endtask
  // Downstream: bp_mode 1 holds ready low 5 cycles per result, 2 is random, 0 always ready.
  initial begin
    int hold;
    hold = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1 && bus.out_valid && hold < 5) begin
        bus.out_ready = 1'b0;
        hold++;
      end else begin
        bus.out_ready = bp_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!bus.out_valid) hold = 0;
      end
    end
  end
  initial begin
    logic held;
    logic [7:0] po;
    logic [3:0] pi;
    exp_t e;
    held = 1'b0;
    po = '0;
    pi = '0;
    forever begin
      @(negedge clk);
      if (rst) held = 1'b0;
      else if (bus.out_valid) begin
        chk("w_ready_in_emit", int'(bus.w_ready), 0);
        if (held) begin
          chk("out_stable", int'(bus.out), int'(po));
          chk("idx_stable", int'(bus.out_idx), int'(pi));
        end
        if (bus.out_ready) begin
          chk("sb_depth", sb.size(), 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out_value", int'(bus.out), e.out);
            chk("out_idx", int'(bus.out_idx), e.idx);
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          po = bus.out;
          pi = bus.out_idx;
        end
      end else held = 1'b0;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.din = '0;
    bus.din_valid = 1'b0;
    bus.w = '0;
    bus.w_valid = 1'b0;
    repeat (3) tick();
    chk("reset_state", outs_word(), 0);
    rst = 1'b0;
    tick();
    chk("idle_state", outs_word(), 0);
    set_basic();
    run_pass(1'b0, 1'b0, 1'b0, -1);
    xv = '{127, 127, 127, 127};
    wv = '{'{127, 127, 127, 127}, '{-127, -127, -127, -127}};
    bv = '{0, 0};
    run_pass(1'b0, 1'b0, 1'b0, -1);
    xv = '{-128, -128, -128, -128};
    wv = '{'{127, 127, 127, 127}, '{-128, -128, -128, -128}};
    bv = '{-128, 127};
    run_pass(1'b0, 1'b0, 1'b0, -1);
    xv = '{127, 1, 0, 0};
    wv = '{'{4, 3, 0, 0}, '{0, 4, 0, 0}};
    bv = '{0, 0};
    run_pass(1'b0, 1'b0, 1'b0, -1);
    xv = '{8, 8, 8, 8};
    wv = '{'{1, 1, 1, 1}, '{1, 1, 1, 1}};
    run_pass(1'b0, 1'b0, 1'b0, -1);
    set_basic();
    run_pass(1'b0, 1'b0, 1'b0, 2);
    tick();
    chk("idle_after_abort", int'(bus.busy), 0);
    run_pass(1'b0, 1'b0, 1'b0, -1);
    bp_mode = 1;
    run_pass(1'b1, 1'b0, 1'b0, -1);
    bp_mode = 0;
    for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < N_OUT; j++) for (int i = 0; i < N_IN; i++) wv[j][i] = int'($urandom_range(0, 8)) - 4;
    run_pass(1'b0, 1'b1, 1'b1, -1);
    bp_mode = 2;
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < N_IN; i++) xv[i] = int'($urandom_range(0, 255)) - 128;
      for (int j = 0; j < N_OUT; j++) begin
        bv[j] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < N_IN; i++)
          wv[j][i] = p % 2 == 0 ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 8)) - 4;
      end
      run_pass(p % 3 == 0, p % 4 == 1, p % 5 == 2, -1);
    end
    bp_mode = 0;
    repeat (3) tick();
    chk("sb_final_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
